elixirchip_es1_spu_op_logic: RTL

Parametrised successor to the single-function SPU XOR op. Performs a per-cycle selectable bitwise logic operation (8 ops) on two operands, with an optional accumulate mode in which operand 1 is replaced by the block's own running result. Output passes through a LATENCY-stage cke-gated pipeline and carries a valid flag. Sits in the SPU datapath alongside the other es1_spu_op_* blocks.

---
 rtl/elixirchip_es1_spu_op_logic_pkg.sv | 40 ++++
 rtl/elixirchip_es1_spu_valid_delay.sv | 61 ++++++
 rtl/elixirchip_es1_spu_op_logic.sv | 134 +++++++++++++
 3 files changed

// File: rtl/elixirchip_es1_spu_op_logic_pkg.sv
// Shared definitions for the SPU bitwise-logic op.
//   op_t      : 3-bit operation select.
//   logic_op  : reference evaluation of one op, used by the datapath and by
//               any checker that needs the same function. It works on a wide
//               word so that callers of any width up to LOGIC_MAX_BITS can
//               zero-extend their operands and truncate the result. Bitwise
//               ops never carry between bit positions, so this is exact.
package elixirchip_es1_spu_op_logic_pkg;

  localparam int LOGIC_MAX_BITS = 256;

  typedef logic [LOGIC_MAX_BITS-1:0] logic_word_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  function automatic logic_word_t logic_op(op_t op, logic_word_t d0, logic_word_t b);
    logic_word_t r;
    case (op)
      OP_AND:  r = d0 & b;
      OP_OR:   r = d0 | b;
      OP_XOR:  r = d0 ^ b;
      OP_XNOR: r = ~(d0 ^ b);
      OP_NAND: r = ~(d0 & b);
      OP_NOR:  r = ~(d0 | b);
      OP_ANDN: r = d0 & ~b;
      default: r = d0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_valid_delay.sv
// cke-gated valid/data shift pipeline with load-on-valid.
// STAGES registers deep (STAGES >= 1). The valid bit shifts on every cke
// edge; a stage's data register loads only when the stage feeding it holds a
// valid word, so m_data changes only on an edge where m_valid becomes 1.
// Ports:
//   reset   async active-high reset; all valids 0, all data RESET_DATA
//   clk     clock
//   cke     clock enable; everything freezes when low
//   s_data  / s_valid  input word and its valid
//   m_data  / m_valid  last stage
module elixirchip_es1_spu_valid_delay #(
  parameter int    STAGES     = 1,
  parameter type   data_t     = logic [7:0],
  parameter data_t RESET_DATA = '0
) (
  input  logic  reset,
  input  logic  clk,
  input  logic  cke,
  input  data_t s_data,
  input  logic  s_valid,
  output data_t m_data,
  output logic  m_valid
);

  logic  [STAGES-1:0] stage_valid;
  data_t              stage_data [STAGES];

  // What feeds each stage: the module input for stage 0, the previous
  // register otherwise.
  logic  [STAGES-1:0] prev_valid;
  data_t              prev_data [STAGES];

  always_comb begin
    prev_valid[0] = s_valid;
    prev_data[0]  = s_data;
    for (int i = 1; i < STAGES; i++) begin
      prev_valid[i] = stage_valid[i-1];
      prev_data[i]  = stage_data[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_data[i] <= RESET_DATA;
      end
    end else if (cke) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_valid[i] <= prev_valid[i];
        if (prev_valid[i]) begin
          stage_data[i] <= prev_data[i];
        end
      end
    end
  end

  assign m_data  = stage_data[STAGES-1];
  assign m_valid = stage_valid[STAGES-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_logic.sv
// SPU bitwise-logic op: one of eight bitwise ops per cycle on two operands,
// with an accumulate mode in which operand 1 is the block's own last result.
// Stage 1 evaluates the op and updates the accumulator; stages 2..LATENCY are
// a load-on-valid delay line, so a result appears exactly LATENCY cke cycles
// after its input.
//
// Valid semantics: on a clk edge with cke=1, s_clear or s_valid qualifies the
// inputs. There is no backpressure; every accepted input produces exactly one
// m_valid=1 cycle LATENCY cke edges later, in order. m_data holds its last
// value whenever m_valid=0.
//
// Ports:
//   reset    async active-high reset
//   clk      clock
//   cke      clock enable; all state (including the accumulator) freezes low
//   s_op     op_t encoding of the operation
//   s_data0  operand 0
//   s_data1  operand 1 (ignored when s_acc=1)
//   s_acc    use the accumulator as operand 1
//   s_clear  load CLEAR_DATA into result and accumulator (beats s_valid)
//   s_valid  input valid
//   m_data   result
//   m_valid  result valid
module elixirchip_es1_spu_op_logic
  import elixirchip_es1_spu_op_logic_pkg::*;
#(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter data_t RESET_DATA = '0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        cke,
  input  logic  [2:0] s_op,
  input  data_t       s_data0,
  input  data_t       s_data1,
  input  logic        s_acc,
  input  logic        s_clear,
  input  logic        s_valid,
  output data_t       m_data,
  output logic        m_valid
);

  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_logic: LATENCY=%0d outside 1..16", LATENCY);
  end

  if (DATA_BITS < 1 || DATA_BITS > LOGIC_MAX_BITS) begin : g_bad_width
    $error("elixirchip_es1_spu_op_logic: DATA_BITS=%0d outside 1..%0d",
           DATA_BITS, LOGIC_MAX_BITS);
  end

  if (DEVICE == "") begin : g_bad_device
    $error("elixirchip_es1_spu_op_logic: DEVICE must name a target");
  end

  // ---------------------------------------------------------------------
  // Stage 1: op evaluation and accumulator
  // ---------------------------------------------------------------------
  data_t acc;
  data_t st1_data;
  logic  st1_valid;
  data_t op_b;
  data_t op_result;

  assign op_b = s_acc ? acc : s_data1;

  // Operands are zero-extended into the package word and the result is
  // truncated back; bitwise ops make the upper bits irrelevant.
  assign op_result = data_t'(logic_op(op_t'(s_op),
                                      logic_word_t'(s_data0),
                                      logic_word_t'(op_b)));

  // The accumulator is written in the same edge as the stage register, so a
  // back-to-back s_acc op already sees the previous result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st1_valid <= 1'b0;
      st1_data  <= RESET_DATA;
      acc       <= RESET_DATA;
    end else if (cke) begin
      if (s_clear) begin
        st1_valid <= 1'b1;
        st1_data  <= CLEAR_DATA;
        acc       <= CLEAR_DATA;
      end else if (s_valid) begin
        st1_valid <= 1'b1;
        st1_data  <= op_result;
        acc       <= op_result;
      end else begin
        st1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stages 2..LATENCY
  // ---------------------------------------------------------------------
  if (LATENCY > 1) begin : g_delay
    elixirchip_es1_spu_valid_delay #(
      .STAGES     (LATENCY - 1),
      .data_t     (data_t),
      .RESET_DATA (RESET_DATA)
    ) u_valid_delay (
      .reset   (reset),
      .clk     (clk),
      .cke     (cke),
      .s_data  (st1_data),
      .s_valid (st1_valid),
      .m_data  (m_data),
      .m_valid (m_valid)
    );
  end else begin : g_no_delay
    assign m_data  = st1_data;
    assign m_valid = st1_valid;
  end

  // ---------------------------------------------------------------------
  // Simulation-only invariants
  // ---------------------------------------------------------------------
  if (SIMULATION == "true" || DEBUG == "true") begin : g_check
    a_known : assert property (@(posedge clk) disable iff (reset)
      !$isunknown({m_valid, m_data}));
    // A cke-low edge must leave the output untouched.
    a_freeze : assert property (@(posedge clk) disable iff (reset)
      !cke |=> $stable(m_data));
  end

endmodule
